// File: rtl/iter_div.sv
// Iterative restoring divider. Handles signed and unsigned operands with RISC-V
// special results. It produces one quotient bit per cycle, so latency is fixed:
// out_valid rises W+1 edges after the accepting edge, the accepting edge included.
module iter_div #(
    parameter int W  = 64,
    parameter int TW = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_signed,
    input  logic          in_rem,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_y,
    output logic [TW-1:0] out_tag
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_DONE
    } state_e;

    // Control and output registers (reset)
    state_e        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  out_y_q;
    logic [TW-1:0] out_tag_q;

    // Operation registers (loaded on accept, not reset)
    logic [W-1:0]  rem_q;       // partial remainder
    logic [W-1:0]  dvd_q;       // dividend bits shift out at the top, quotient bits shift in at the bottom
    logic [W-1:0]  dsr_q;       // divisor magnitude
    logic [TW-1:0] tag_q;
    logic          want_rem_q;
    logic          neg_quo_q;
    logic          neg_rem_q;
    logic          div_zero_q;

    // Accept-side operand preparation
    logic          accept;
    logic          a_neg;
    logic          b_neg;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;

    // One restoring step
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          q_bit;
    logic [W-1:0]  rem_d;
    logic [W-1:0]  dvd_d;

    // Final result after sign fix-up
    logic [W-1:0]  quo_fix;
    logic [W-1:0]  rem_fix;
    logic [W-1:0]  result_d;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_tag   = out_tag_q;

    // in_ready_q is high exactly in IDLE, so it doubles as the state qualifier.
    assign accept = in_valid & in_ready_q & ~flush;

    assign a_neg = in_signed & in_a[W-1];
    assign b_neg = in_signed & in_b[W-1];
    // The most negative value negates to itself. Read as unsigned, that is its
    // correct magnitude.
    assign a_mag = a_neg ? (W'(0) - in_a) : in_a;
    assign b_mag = b_neg ? (W'(0) - in_b) : in_b;

    // Bring in the next dividend bit, then try to subtract the divisor.
    assign shifted = {rem_q, dvd_q[W-1]};

    iter_div_addsub #(
        .N (W + 1)
    ) u_step_sub (
        .a_i      (shifted),
        .b_i      ({1'b0, dsr_q}),
        .is_sub_i (1'b1),
        .y_o      (diff)
    );

    // A clear MSB means no borrow: the subtraction fits, so keep it.
    assign q_bit = ~diff[W];
    assign rem_d = q_bit ? diff[W-1:0] : shifted[W-1:0];
    assign dvd_d = {dvd_q[W-2:0], q_bit};

    // With a zero divisor every step succeeds, so the quotient is all ones and the
    // remainder is |a|. The sign fix-up on the remainder restores a, but the
    // quotient must bypass the fix-up. The MIN / -1 overflow needs no special
    // path: 2^(W-1) negates to itself modulo 2^W.
    assign quo_fix  = div_zero_q ? '1 : (neg_quo_q ? (W'(0) - dvd_d) : dvd_d);
    assign rem_fix  = neg_rem_q ? (W'(0) - rem_d) : rem_d;
    assign result_d = want_rem_q ? rem_fix : quo_fix;

    // Operation datapath: load the operands on accept, then run one step per DIVIDE cycle.
    // NOTE: these registers are always written before they are read, so they carry no
    // reset. Only the control and output registers need a defined value out of reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q      <= '0;
            dvd_q      <= a_mag;
            dsr_q      <= b_mag;
            tag_q      <= in_tag;
            want_rem_q <= in_rem;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= (in_b == '0);
        end else if (state_q == S_DIVIDE) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
        end
    end

    // Control FSM with registered handshake and result outputs.
    // NOTE: state registers use non-blocking assignments, so every branch reads the
    // values from before the clock edge, whatever the statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            out_y_q     <= '0;
            out_tag_q   <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q    <= S_DIVIDE;
                        in_ready_q <= 1'b0;
                        cnt_q      <= CW'(W - 1);
                    end
                end
                S_DIVIDE: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_y_q     <= result_d;
                        out_tag_q   <= tag_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// Shared N-bit adder/subtractor: y = a + b, or y = a - b when is_sub_i is set.
module iter_div_addsub #(
    parameter int N = 65
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         is_sub_i,
    output logic [N-1:0] y_o
);

    logic [N-1:0] b_eff;

    // Two's-complement subtract: invert b and add one through the carry-in term.
    assign b_eff = is_sub_i ? ~b_i : b_i;
    assign y_o   = a_i + b_eff + N'(is_sub_i);

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have parameter W, default 64, operand/result width in bits (even, >=8).
REQ-002 SHALL have parameter TW, default 6, tag width in bits.
REQ-003 SHALL have port clk  input  1  clock, all state rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port in_a  input  W  dividend.
REQ-009 SHALL have port in_b  input  W  divisor.
REQ-010 SHALL have port in_signed  input  1  two's-complement operands when 1, unsigned when 0.
REQ-011 SHALL have port in_rem  input  1  return remainder when 1, quotient when 0.
REQ-012 SHALL have port in_tag  input  TW  opaque tag returned with result.
REQ-013 SHALL have port out_valid  output  1  result present.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port out_y  output  W  quotient or remainder.
REQ-016 SHALL have port out_tag  output  TW  tag of the request producing out_y.

Function
REQ-017 SHALL implement a 3-state FSM: IDLE, DIVIDE, DONE.
REQ-018 SHALL drive in_ready=1 only in IDLE; accept occurs on an edge with in_valid & in_ready & !flush.
REQ-019 SHALL on accept: latch tag, in_rem, sign flags; store |in_a|, |in_b| (magnitudes when in_signed, raw otherwise); clear partial remainder; load iteration counter W-1; go to DIVIDE.
REQ-020 SHALL in DIVIDE perform one restoring step per cycle: shifted remainder {rem[W-1:0], dividend MSB} minus {1'b0, divisor} computed by an instance of the team's W+1-bit addsub block with is_sub=1.
REQ-021 SHALL keep the difference and shift quotient bit 1 when the difference MSB is 0; otherwise keep the shifted remainder and shift quotient bit 0.
REQ-022 SHALL leave DIVIDE for DONE on the edge where counter is 0; total W edges in DIVIDE.
REQ-023 SHALL apply result sign fix-up on the DIVIDE->DONE edge: quotient negated when in_signed and operand signs differ; remainder negated when in_signed and dividend negative.
REQ-024 SHALL produce RISC-V special results: divisor 0 -> quotient all-ones, remainder = in_a; signed in_a = 2^(W-1) with in_b = -1 -> quotient = in_a, remainder 0.
REQ-025 SHALL use fixed latency: out_valid first high after exactly W+1 edges from the accepting edge, special cases included.
REQ-026 SHALL assert out_valid only in DONE, with out_y/out_tag stable while out_valid & !out_ready.
REQ-027 SHALL return DONE->IDLE on an edge with out_ready=1; no new request accepted in that same edge.
REQ-028 SHALL on flush=1 go to IDLE on the next edge from any state, dropping any result; flush wins over simultaneous accept and out_ready.
REQ-029 SHALL compute all arithmetic modulo 2^W; magnitude of 2^(W-1) treated as unsigned W-bit value.

Reset
REQ-030 SHALL on reset_n=0 immediately set state IDLE, in_ready=1, out_valid=0, out_y=0, out_tag=0, counter=0.
REQ-031 SHALL abandon an in-flight operation when reset asserts mid-DIVIDE or in DONE; no result is produced afterwards.

Verification
REQ-032 SHALL check unsigned: in_a=100, in_b=7, in_rem=0, tag=5 -> out_valid after 65 edges, out_y=14, out_tag=5; in_rem=1 -> out_y=2.
REQ-033 SHALL check signed: in_a=-7, in_b=2 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD), remainder -1.
REQ-034 SHALL check specials: in_b=0, in_a=0x1234 -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 0x1234; signed 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000, remainder 0.
REQ-035 SHALL check backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, out_y, out_tag constant, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-036 SHALL check flush at DIVIDE cycle 30 with in_valid=1 -> IDLE next edge, no out_valid, new request accepted the following edge and completes correctly.
REQ-037 SHALL check reset_n pulsed low mid-DIVIDE -> outputs at reset values asynchronously, no stale out_valid after release.
